// File: rtl/rom_loader_pkg.sv
// Shared types and helpers for the expansion-ROM page loader.
package rom_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StParse,
        StLoad,
        StCombo2,
        StDrain
    } loader_state_e;

    localparam logic [7:0] ChZero = 8'h30;  // "0"
    localparam logic [7:0] ChNine = 8'h39;  // "9"
    localparam logic [7:0] ChA    = 8'h41;  // "A"
    localparam logic [7:0] ChF    = 8'h46;  // "F"
    localparam logic [7:0] ChZ    = 8'h5A;  // "Z"

    // Returns {valid, nibble}; only upper-case hex digits are accepted.
    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        logic [4:0] r;
        r = 5'b0;
        if (c >= ChZero && c <= ChNine) begin
            r = {1'b1, c[3:0]};
        end else if (c >= ChA && c <= ChF) begin
            r = {1'b1, c[3:0] + 4'd9};
        end
        return r;
    endfunction

endpackage

// File: rtl/rom_page_map.sv
// Per-page "loaded" bitmap with set, synchronous clear and registered lookup.
module rom_page_map #(
    parameter int unsigned PAGE_BITS = 8
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic                 set_en,
    input  logic [PAGE_BITS-1:0] set_page,
    input  logic                 clear,
    input  logic [PAGE_BITS-1:0] rd_page,
    output logic                 rd_hit
);

    logic [(2**PAGE_BITS)-1:0] map_q;

    // Map storage: clear beats set; reset deliberately leaves the map alone.
    always_ff @(posedge clk_sys) begin
        if (clear) begin
            map_q <= '0;
        end else if (set_en) begin
            map_q[set_page] <= 1'b1;
        end
    end

    // Registered lookup sees the pre-update map contents.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            rd_hit <= 1'b0;
        end else begin
            rd_hit <= map_q[rd_page];
        end
    end

endmodule

// File: rtl/rom_page_loader.sv
// Turns an ioctl expansion-ROM download into SDRAM boot writes, one page per 2**OFS_BITS bytes.
module rom_page_loader
    import rom_loader_pkg::*;
#(
    parameter int unsigned          PAGE_BITS = 8,
    parameter int unsigned          OFS_BITS  = 14,
    parameter logic [PAGE_BITS-1:0] MF2_PAGE  = '1,
    parameter logic [PAGE_BITS-1:0] DUMP_PAGE = PAGE_BITS'('hEE)
) (
    input  logic                          clk_sys,
    input  logic                          reset,
    input  logic                          ioctl_download,
    input  logic                          ioctl_wr,
    input  logic [24:0]                   ioctl_addr,
    input  logic [7:0]                    ioctl_dout,
    input  logic [7:0]                    ioctl_index,
    input  logic [15:0]                   ioctl_file_ext,
    input  logic                          clear_map,
    input  logic [PAGE_BITS-1:0]          map_addr,
    output logic                          map_hit,
    output logic                          boot_wr,
    output logic [PAGE_BITS+OFS_BITS:0]   boot_a,
    output logic [7:0]                    boot_dout,
    output logic                          busy,
    output logic                          err_ext,
    output logic                          err_ovf,
    output logic [PAGE_BITS:0]            pages_loaded
);

    loader_state_e state_q, state_d;

    logic                 dl_q, wr_q;
    logic [PAGE_BITS-1:0] base_q;
    logic                 combo_q;
    logic [PAGE_BITS-1:0] last_page_q;
    logic                 last_full_q;
    logic [PAGE_BITS:0]   cnt_q;

    logic dl_rise, dl_fall, wr_fall, complete;
    assign dl_rise  = ioctl_download & ~dl_q;
    assign dl_fall  = ~ioctl_download & dl_q;
    assign wr_fall  = wr_q & ~ioctl_wr;
    // last_full_q only rises for an accepted write to the final offset of a page.
    assign complete = wr_fall & last_full_q;

    // Page arithmetic keeps the carry so overflow is detected instead of wrapping.
    logic [31:0]          addr_ext;
    logic [PAGE_BITS-1:0] addr_page;
    logic                 addr_high;
    logic [PAGE_BITS:0]   page_sum;
    assign addr_ext  = {7'b0, ioctl_addr};
    assign addr_page = PAGE_BITS'(addr_ext >> OFS_BITS);
    assign addr_high = (addr_ext >> (OFS_BITS + PAGE_BITS)) != 32'd0;
    assign page_sum  = {1'b0, base_q} + {1'b0, addr_page};

    // Extension decode into base page, combo mode and malformed flag.
    logic [4:0]           hi_dec, lo_dec;
    logic [PAGE_BITS-1:0] parse_base;
    logic                 parse_combo, parse_bad;
    always_comb begin
        hi_dec      = hex_decode(ioctl_file_ext[15:8]);
        lo_dec      = hex_decode(ioctl_file_ext[7:0]);
        parse_base  = '0;
        parse_combo = 1'b0;
        parse_bad   = 1'b0;
        if (ioctl_file_ext == {ChZ, ChZ}) begin
            parse_base = '0;
        end else if (ioctl_file_ext == {ChZ, ChZero}) begin
            parse_combo = 1'b1;
        end else if (hi_dec[4] && lo_dec[4]) begin
            parse_base = PAGE_BITS'({hi_dec[3:0], lo_dec[3:0]});
        end else begin
            parse_bad  = 1'b1;
            parse_base = DUMP_PAGE;
        end
    end

    // State register.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a dropped download aborts from any active state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (dl_rise && ioctl_index != 8'd0) state_d = StParse;
            StParse:  state_d = StLoad;
            StLoad:   if (complete && combo_q && last_page_q == '0) state_d = StCombo2;
            StCombo2: if (complete) state_d = StDrain;
            StDrain:  state_d = StDrain;
            default:  state_d = StIdle;
        endcase
        if (dl_fall && state_q != StIdle) begin
            state_d = StIdle;
        end
    end

    // Output decode: target page/offset and whether this byte is written or dropped.
    logic [PAGE_BITS-1:0] wr_page;
    logic [OFS_BITS-1:0]  wr_ofs;
    logic                 wr_ok, wr_bad;
    always_comb begin
        wr_page = page_sum[PAGE_BITS-1:0];
        wr_ofs  = ioctl_addr[OFS_BITS-1:0];
        wr_ok   = 1'b0;
        wr_bad  = 1'b0;
        unique case (state_q)
            StLoad: begin
                if (ioctl_wr) begin
                    if (page_sum[PAGE_BITS] || addr_high) wr_bad = 1'b1;
                    else wr_ok = 1'b1;
                end
            end
            StCombo2: begin
                wr_page = MF2_PAGE;
                wr_ok   = ioctl_wr;
            end
            StDrain:  wr_bad = ioctl_wr;
            default:  wr_ok = 1'b0;
        endcase
    end

    // Edge detectors for download and write strobe.
    always_ff @(posedge clk_sys) begin
        dl_q <= ioctl_download;
        wr_q <= ioctl_wr;
    end

    // Datapath: boot write stage, parse results, flags and page counter.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            boot_wr     <= 1'b0;
            boot_a      <= '0;
            boot_dout   <= 8'd0;
            base_q      <= '0;
            combo_q     <= 1'b0;
            last_page_q <= '0;
            last_full_q <= 1'b0;
            err_ext     <= 1'b0;
            err_ovf     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            boot_wr <= wr_ok;
            if (wr_ok) begin
                boot_a    <= {1'b1, wr_page, wr_ofs};
                boot_dout <= ioctl_dout;
            end
            if (ioctl_wr) begin
                last_page_q <= wr_page;
                last_full_q <= wr_ok && (wr_ofs == '1);
            end
            if (state_q == StIdle && state_d == StParse) begin
                err_ext <= 1'b0;
                err_ovf <= 1'b0;
                cnt_q   <= '0;
            end
            if (state_q == StParse) begin
                base_q  <= parse_base;
                combo_q <= parse_combo;
                err_ext <= parse_bad;
            end
            if (wr_bad) begin
                err_ovf <= 1'b1;
            end
            if (complete && cnt_q != '1) begin
                cnt_q <= cnt_q + (PAGE_BITS+1)'(1);
            end
        end
    end

    assign busy         = (state_q != StIdle);
    assign pages_loaded = cnt_q;

    rom_page_map #(
        .PAGE_BITS(PAGE_BITS)
    ) u_map (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .set_en   (complete && !err_ext),
        .set_page (last_page_q),
        .clear    (clear_map),
        .rd_page  (map_addr),
        .rd_hit   (map_hit)
    );

endmodule

// File: tb/tb_rom_page_loader.sv
// Scoreboard bench: sparse randomized byte streams, expected boot writes queued per byte.
module tb_rom_page_loader;

    localparam int PageSize = 16384;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic [7:0]  ioctl_index = '0;
    logic [15:0] ioctl_file_ext = '0;
    logic        clear_map = 1'b0;
    logic [7:0]  map_addr = '0;
    logic        map_hit;
    logic        boot_wr;
    logic [22:0] boot_a;
    logic [7:0]  boot_dout;
    logic        busy;
    logic        err_ext;
    logic        err_ovf;
    logic [8:0]  pages_loaded;

    rom_page_loader dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_index    (ioctl_index),
        .ioctl_file_ext (ioctl_file_ext),
        .clear_map      (clear_map),
        .map_addr       (map_addr),
        .map_hit        (map_hit),
        .boot_wr        (boot_wr),
        .boot_a         (boot_a),
        .boot_dout      (boot_dout),
        .busy           (busy),
        .err_ext        (err_ext),
        .err_ovf        (err_ovf),
        .pages_loaded   (pages_loaded)
    );

    initial forever #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    typedef struct {
        logic [22:0] addr;
        logic [7:0]  data;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    bit   exp_map[256];
    bit   exp_ext = 0, exp_ovf = 0;
    int   exp_cnt = 0;
    bit   idx0_active = 0;
    bit   busy_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic int hexval(input logic [7:0] c);
        if (c >= "0" && c <= "9") return int'(c) - 48;
        if (c >= "A" && c <= "F") return int'(c) - 55;
        return -1;
    endfunction

    // Monitor: every boot write must match the oldest queued expectation.
    initial forever begin
        @(negedge clk_sys);
        if (idx0_active && busy) busy_seen = 1;
        if (!reset && boot_wr) begin
            if (exp_q.size() == 0) begin
                check("boot_wr_unexpected", boot_wr, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("boot_a", boot_a, e.addr);
                check("boot_dout", boot_dout, e.data);
                check("boot_wr_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic send_byte(input int a, input bit expect_wr, input int page);
        logic [7:0] d;
        @(posedge clk_sys); #1;
        d = 8'($urandom);
        ioctl_addr = 25'(a);
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        if (expect_wr)
            exp_q.push_back('{addr: {1'b1, 8'(page), 14'(a % PageSize)}, data: d, cyc: cyc + 1});
        @(posedge clk_sys); #1;
        ioctl_wr = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge clk_sys);
    endtask

    task automatic lookup(input int p);
        @(posedge clk_sys); #1;
        map_addr = 8'(p);
        @(posedge clk_sys); #1;
        check($sformatf("map_hit[%0h]", p), map_hit, exp_map[p]);
    endtask

    task automatic check_all_maps(input int extra);
        int pages[10] = '{0, 3, 5, 7, 8, 'hEE, 'hEF, 'hFE, 'hFF, 0};
        pages[9] = extra;
        foreach (pages[i]) lookup(pages[i]);
    endtask

    // One whole file: model decides per chunk which page it lands on, or none.
    task automatic run_file(input logic [7:0] idx, input logic [15:0] ext, input int nbytes);
        int  hi, lo, base, nchunks, done;
        bit  combo, bad, ovf;
        hi = hexval(ext[15:8]);
        lo = hexval(ext[7:0]);
        combo = 0; bad = 0; ovf = 0; base = 0; done = 0;
        if (ext == "ZZ") base = 0;
        else if (ext == "Z0") combo = 1;
        else if (hi >= 0 && lo >= 0) base = hi * 16 + lo;
        else begin bad = 1; base = 'hEE; end
        nchunks = (nbytes + PageSize - 1) / PageSize;
        idx0_active = (idx == 0);
        @(posedge clk_sys); #1;
        ioctl_index    = idx;
        ioctl_file_ext = ext;
        ioctl_download = 1'b1;
        repeat (3) @(posedge clk_sys);
        for (int k = 0; k < nchunks; k++) begin
            int  first, last, page;
            bit  ok;
            first = k * PageSize;
            last  = ((nbytes < first + PageSize) ? nbytes : first + PageSize) - 1;
            if (combo) begin
                ok   = (k < 2);
                page = (k == 0) ? 0 : 255;
            end else begin
                page = base + k;
                ok   = (page < 256);
            end
            if (idx == 0) ok = 0;
            for (int j = 0; j < 7; j++) begin
                int a;
                a = (j == 6) ? last : first + ((last - first) * j) / 6;
                send_byte(a, ok, page);
            end
            if (idx != 0 && !ok) ovf = 1;
            if (ok && (last - first) == PageSize - 1) begin
                done++;
                if (!bad) exp_map[page] = 1;
            end
        end
        @(posedge clk_sys); #1;
        ioctl_download = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1;
        if (idx != 0) begin
            exp_ext = bad;
            exp_ovf = ovf;
            exp_cnt = done;
        end
        check($sformatf("err_ext[%s]", ext), err_ext, exp_ext);
        check($sformatf("err_ovf[%s]", ext), err_ovf, exp_ovf);
        check($sformatf("pages_loaded[%s]", ext), pages_loaded, exp_cnt);
        check($sformatf("busy_after[%s]", ext), busy, 0);
        check_all_maps(base < 256 ? base : 0);
        idx0_active = 0;
    endtask

    initial begin
        // Runaway guard in case the bench stalls.
        #5000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rext;
        foreach (exp_map[i]) exp_map[i] = 0;
        clear_map = 1'b1;
        repeat (4) @(posedge clk_sys);
        #1;
        clear_map = 1'b0;
        reset = 1'b0;
        @(negedge clk_sys);
        check("rst_boot_wr", boot_wr, 0);
        check("rst_boot_a", boot_a, 0);
        check("rst_boot_dout", boot_dout, 0);
        check("rst_busy", busy, 0);
        check("rst_err_ext", err_ext, 0);
        check("rst_err_ovf", err_ovf, 0);
        check("rst_pages_loaded", pages_loaded, 0);
        check("rst_map_hit", map_hit, 0);

        run_file(8'd1, "07", 2 * PageSize);
        run_file(8'd1, "Z0", 3 * PageSize);
        run_file(8'd1, "FE", 3 * PageSize);
        run_file(8'd1, "G1", PageSize + 4096);
        run_file(8'd1, "05", PageSize);
        run_file(8'd1, "03", 10240);

        @(posedge clk_sys); #1;
        clear_map = 1'b1;
        @(posedge clk_sys); #1;
        clear_map = 1'b0;
        foreach (exp_map[i]) exp_map[i] = 0;
        lookup(5);
        lookup(7);

        busy_seen = 0;
        run_file(8'd0, "07", 2 * PageSize);
        check("busy_idx0", busy_seen, 0);

        for (int r = 0; r < 4; r++) begin
            int n1, n2;
            n1 = $urandom_range(0, 15);
            n2 = $urandom_range(0, 15);
            rext = {8'((n1 < 10) ? 48 + n1 : 55 + n1), 8'((n2 < 10) ? 48 + n2 : 55 + n2)};
            run_file(8'($urandom_range(1, 255)), rext, $urandom_range(1, 3 * PageSize));
        end

        check("exp_q_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
